// File: rtl/miriscv_alu_pkg.sv
// Operator codes, FSM encoding and op classification for the sequential ALU.
package miriscv_alu_pkg;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b01000;
  localparam logic [4:0] ALU_SLL    = 5'b00001;
  localparam logic [4:0] ALU_LTS    = 5'b00010;
  localparam logic [4:0] ALU_LTU    = 5'b00011;
  localparam logic [4:0] ALU_XOR    = 5'b00100;
  localparam logic [4:0] ALU_SRL    = 5'b00101;
  localparam logic [4:0] ALU_SRA    = 5'b01101;
  localparam logic [4:0] ALU_OR     = 5'b00110;
  localparam logic [4:0] ALU_AND    = 5'b00111;
  localparam logic [4:0] ALU_EQF    = 5'b11000;
  localparam logic [4:0] ALU_NEF    = 5'b11001;
  localparam logic [4:0] ALU_LTSF   = 5'b11100;
  localparam logic [4:0] ALU_GESF   = 5'b11101;
  localparam logic [4:0] ALU_LTUF   = 5'b11110;
  localparam logic [4:0] ALU_GEUF   = 5'b11111;
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_e;
  typedef enum logic [1:0] {CLS_BASE, CLS_MUL, CLS_DIV, CLS_ILL} op_class_e;

  function automatic op_class_e op_class(input logic [4:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_LTS, ALU_LTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_EQF, ALU_NEF, ALU_LTSF, ALU_GESF, ALU_LTUF,
      ALU_GEUF:                                       return CLS_BASE;
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU:       return CLS_MUL;
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU:           return CLS_DIV;
      default:                                        return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/miriscv_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// done_o is combinational and flags the final iteration; quo_o/rem_o are its results.
module miriscv_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);
  localparam int CW = $clog2(XLEN);

  logic            busy;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo, rem, dsr;
  logic [XLEN:0]   shifted, diff;
  logic            ge;

  // Partial remainder stays below the divisor, so XLEN+1 bits hold the trial subtraction.
  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, dsr};
  assign ge      = ~diff[XLEN];
  assign quo_o   = {quo[XLEN-2:0], ge};
  assign rem_o   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign done_o  = busy && (cnt == '0);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      busy <= 1'b0;
      cnt  <= '0;
      quo  <= '0;
      rem  <= '0;
      dsr  <= '0;
    end else if (kill_i) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start_i) begin
      busy <= 1'b1;
      cnt  <= CW'(XLEN-1);
      quo  <= dividend_i;
      rem  <= '0;
      dsr  <= divisor_i;
    end else if (busy) begin
      quo <= quo_o;
      rem <= rem_o;
      cnt <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/miriscv_alu_seq.sv
// Handshaked execute-stage ALU: single-cycle base ops, iterative MUL*, and
// iterative DIV/REM* when built with MIRISCV_DIV_EN (otherwise those codes are illegal).
module miriscv_alu_seq
  import miriscv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      operator_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            kill_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            comparison_result_o,
  output logic            illegal_o
);
  localparam int SW = $clog2(XLEN);

  state_e          state, state_nx;
  op_class_e       cls;
  logic [SW-1:0]   cnt;
  logic            accept;
  logic [XLEN-1:0] a, b;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] base_res;
  logic            base_flag;
  logic            done_nx, flag_nx, ill_nx;
  logic [XLEN-1:0] res_nx;

  assign a       = operand_a_i;
  assign b       = operand_b_i;
  assign shamt   = b[SW-1:0];
  assign cls     = op_class(operator_i);
  assign ready_o = (state == ST_IDLE);
  assign accept  = valid_i && ready_o && !kill_i;

  always_comb begin
    base_res  = '0;
    base_flag = 1'b0;
    case (operator_i)
      ALU_ADD:  base_res = a + b;
      ALU_SUB:  base_res = a - b;
      ALU_SLL:  base_res = a << shamt;
      ALU_LTS:  base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_LTU:  base_res = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  base_res = a ^ b;
      ALU_SRL:  base_res = a >> shamt;
      ALU_SRA:  base_res = $unsigned($signed(a) >>> shamt);
      ALU_OR:   base_res = a | b;
      ALU_AND:  base_res = a & b;
      ALU_EQF:  base_flag = (a == b);
      ALU_NEF:  base_flag = (a != b);
      ALU_LTSF: base_flag = $signed(a) < $signed(b);
      ALU_GESF: base_flag = $signed(a) >= $signed(b);
      ALU_LTUF: base_flag = a < b;
      ALU_GEUF: base_flag = a >= b;
      default:  ;
    endcase
  end

  // Shift-add multiplier on magnitudes; sign applied to the full product at the end.
  logic [2*XLEN-1:0] mul_acc, mul_mcand, mul_acc_nx, mul_prod;
  logic [XLEN-1:0]   mul_mplier, mul_res, mul_a_mag, mul_b_mag;
  logic              mul_neg, mul_hi, mul_a_sgn, mul_b_sgn;

  assign mul_a_sgn  = (operator_i == ALU_MULH || operator_i == ALU_MULHSU) && a[XLEN-1];
  assign mul_b_sgn  = (operator_i == ALU_MULH) && b[XLEN-1];
  assign mul_a_mag  = mul_a_sgn ? -a : a;
  assign mul_b_mag  = mul_b_sgn ? -b : b;
  assign mul_acc_nx = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  assign mul_prod   = mul_neg ? -mul_acc_nx : mul_acc_nx;
  assign mul_res    = mul_hi ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_neg    <= 1'b0;
      mul_hi     <= 1'b0;
    end else if (accept && cls == CLS_MUL) begin
      mul_acc    <= '0;
      mul_mcand  <= {{XLEN{1'b0}}, mul_a_mag};
      mul_mplier <= mul_b_mag;
      mul_neg    <= mul_a_sgn ^ mul_b_sgn;
      mul_hi     <= (operator_i != ALU_MUL);
    end else if (state == ST_MUL) begin
      mul_acc    <= mul_acc_nx;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
    end
  end

  logic            div_special, div_fin;
  logic [XLEN-1:0] div_special_res, div_res;

`ifdef MIRISCV_DIV_EN
  localparam bit DIV_EN = 1'b1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  logic            div_signed, div_is_rem, div_a_neg, div_b_neg, div_start;
  logic            div_qneg, div_rneg, div_rem_sel;
  logic [XLEN-1:0] div_quo, div_rem;

  assign div_signed  = (operator_i == ALU_DIV) || (operator_i == ALU_REM);
  assign div_is_rem  = (operator_i == ALU_REM) || (operator_i == ALU_REMU);
  assign div_a_neg   = div_signed && a[XLEN-1];
  assign div_b_neg   = div_signed && b[XLEN-1];
  // Divide-by-zero and MIN/-1 never reach the iterative path.
  assign div_special = (b == '0) || (div_signed && a == MIN_VAL && b == '1);
  assign div_start   = accept && cls == CLS_DIV && !div_special;

  always_comb begin
    if (b == '0) div_special_res = div_is_rem ? a : '1;
    else         div_special_res = div_is_rem ? '0 : MIN_VAL;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      div_qneg    <= 1'b0;
      div_rneg    <= 1'b0;
      div_rem_sel <= 1'b0;
    end else if (div_start) begin
      div_qneg    <= div_a_neg ^ div_b_neg;
      div_rneg    <= div_a_neg;
      div_rem_sel <= div_is_rem;
    end
  end

  miriscv_divider #(.XLEN(XLEN)) u_div (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .start_i    (div_start),
    .kill_i     (kill_i),
    .dividend_i (div_a_neg ? -a : a),
    .divisor_i  (div_b_neg ? -b : b),
    .done_o     (div_fin),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

  assign div_res = div_rem_sel ? (div_rneg ? -div_rem : div_rem)
                               : (div_qneg ? -div_quo : div_quo);
`else
  localparam bit DIV_EN = 1'b0;
  assign div_special     = 1'b0;
  assign div_special_res = '0;
  assign div_fin         = 1'b0;
  assign div_res         = '0;
`endif

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    res_nx   = '0;
    flag_nx  = 1'b0;
    ill_nx   = 1'b0;
    case (state)
      ST_IDLE: if (accept) begin
        case (cls)
          CLS_BASE: begin
            done_nx = 1'b1;
            res_nx  = base_res;
            flag_nx = base_flag;
          end
          CLS_MUL: state_nx = ST_MUL;
          CLS_DIV: begin
            if (!DIV_EN) begin
              done_nx = 1'b1;
              ill_nx  = 1'b1;
            end else if (div_special) begin
              done_nx = 1'b1;
              res_nx  = div_special_res;
            end else begin
              state_nx = ST_DIV;
            end
          end
          default: begin
            done_nx = 1'b1;
            ill_nx  = 1'b1;
          end
        endcase
      end
      ST_MUL: begin
        if (kill_i) begin
          state_nx = ST_IDLE;
        end else if (cnt == '0) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
          res_nx   = mul_res;
        end
      end
      ST_DIV: begin
        if (kill_i) begin
          state_nx = ST_IDLE;
        end else if (div_fin) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
          res_nx   = div_res;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)                 cnt <= '0;
    else if (state == ST_IDLE)    cnt <= (state_nx != ST_IDLE) ? SW'(XLEN-1) : '0;
    else if (state_nx == ST_IDLE) cnt <= '0;
    else                          cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      valid_o             <= 1'b0;
      result_o            <= '0;
      comparison_result_o <= 1'b0;
      illegal_o           <= 1'b0;
    end else begin
      valid_o   <= done_nx;
      illegal_o <= ill_nx;
      if (done_nx) begin
        result_o            <= res_nx;
        comparison_result_o <= flag_nx;
      end
    end
  end

endmodule

// File: doc/miriscv_alu_seq.md
# miriscv_alu_seq

Parametrised, handshaked successor to the core ALU: executes all base RV32I/RV64I ALU and branch-flag operations with one-cycle registered latency, and adds RISC-V M-extension multiply/divide as iterative multi-cycle operations. Sits in the execute stage between the decoder/operand mux and writeback. The execute stage stalls on `ready_o` and is flushed via `kill_i`.

## Interface
- `XLEN`, 32: datapath width. Legal values are 32 and 64.
- `clk_i`  input  1: clock, rising edge.
- `arstn_i`  input  1: reset, asynchronous and active-low.
- `valid_i`  input  1: request valid.
- `ready_o`  output  1: block can accept a request this cycle.
- `operator_i`  input  5: operation code.
- `operand_a_i`  input  XLEN: operand A.
- `operand_b_i`  input  XLEN: operand B.
- `kill_i`  input  1: flush. Aborts any in-flight operation.
- `valid_o`  output  1: one-cycle pulse; result is valid.
- `result_o`  output  XLEN: registered result. Holds its value until the next completion.
- `comparison_result_o`  output  1: registered branch flag.
- `illegal_o`  output  1: pulses with `valid_o` when the operator is unsupported.

## Operation
- Base operator codes:
  - ADD 00000, SUB 01000, SLL 00001, LTS 00010, LTU 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111.
  - Flag ops: EQF 11000, NEF 11001, LTSF 11100, GESF 11101, LTUF 11110, GEUF 11111.
- M-extension codes: MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
- Shift amount is `operand_b_i[$clog2(XLEN)-1:0]`. Upper bits are ignored.
- LTS and LTU return a zero-extended 1 or 0.
- Flag ops: `result_o` = 0. Non-flag ops: `comparison_result_o` = 0.
- Unsupported or unknown code: `result_o` = 0, `comparison_result_o` = 0, `illegal_o` = 1. Completes with single-cycle latency.
- State machine has three states: IDLE, MUL, DIV.
  - `ready_o` = 1 only in IDLE.
  - Accept happens when `valid_i && ready_o && !kill_i`.
  - Base ops complete from IDLE and stay in IDLE.
  - MUL* enters MUL; DIV/REM* enters DIV.
  - A down-counter loads XLEN-1 on accept and decrements once per cycle.
  - When the counter reaches 0 with the final iteration done: result registers, `valid_o` pulses, state returns to IDLE.
- Multiplier: radix-2 shift-add on 2·XLEN-bit magnitudes. Sign is applied at the end according to the op.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits.
- Divider: restoring, one quotient bit per cycle, on magnitudes. Signs are fixed up at the end.
  - Quotient sign is sign(A) XOR sign(B).
  - Remainder takes the sign of A.
- Division special cases are decided at accept, complete with single-cycle latency, and do not enter DIV:
  - Divide by zero: quotient = all ones, remainder = A.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- `kill_i` behaviour:
  - In MUL or DIV: returns to IDLE at the next edge, no `valid_o`, outputs unchanged.
  - In IDLE with `valid_i`: the request is dropped and no single-cycle completion occurs.
- Reset values: state IDLE, `ready_o` 1, `valid_o` 0, `result_o` 0, `comparison_result_o` 0, `illegal_o` 0, counter 0. Reset mid-operation discards the operation.

## Timing
- Base op or special case accepted at edge N: `valid_o` is high in cycle N+1. Back-to-back accepts give one result per cycle.
- MUL* or non-special DIV/REM* accepted at edge N:
  - `ready_o` is low for cycles N+1 to N+XLEN.
  - `valid_o` is high in cycle N+XLEN+1 (N+33 for XLEN=32).
  - `ready_o` returns high in the same cycle as `valid_o`, so a new request can be accepted that cycle.
- `valid_o` is never high for more than one cycle per operation.
- `kill_i` and the final iteration on the same edge: kill wins and there is no `valid_o`.
- Inputs are sampled only at accept. Operands may change during MUL or DIV without effect.

## Configuration
- `MIRISCV_DIV_EN` defined: the divider is instantiated and DIV, DIVU, REM, REMU work as specified.
- `MIRISCV_DIV_EN` undefined:
  - No divider hardware. DIV state is unreachable.
  - The four codes are unsupported: single-cycle completion, `result_o` 0, `illegal_o` 1.
  - MUL* are unaffected.

## Structure
- Package `miriscv_alu_pkg` holds:
  - all 24 operator code localparams;
  - the state encoding (IDLE, MUL, DIV);
  - a helper function to classify an op as base, mul or div.
- Sub-module `miriscv_divider`: iterative restoring divider with start/kill/done, parametrised by XLEN. It is instantiated only under `MIRISCV_DIV_EN`.
- The multiplier iteration and the base ALU stay inline in the top.

## Test plan
- Base ops, XLEN=32: SUB 5-7 gives 0xFFFFFFFE; SRA 0x80000000 by 0x21 (shift 1) gives 0xC0000000; GESF -1,1 gives flag 0, result 0. Each completes with one-cycle latency and back-to-back throughput of 1.
- MULH 0x80000000 × 0x80000000 gives 0x40000000. MUL 7 × -3 gives 0xFFFFFFEB. `valid_o` asserts exactly 33 cycles after accept, `ready_o` is low in between, and a new ADD is accepted on the `valid_o` cycle.
- DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIVU 0/0 gives 0xFFFFFFFF at single-cycle latency; DIV 0x80000000/-1 gives 0x80000000 and REM gives 0.
- Kill: accept DIVU, raise `kill_i` at cycle 10. Required: `ready_o` high next cycle, no `valid_o` within 40 cycles, `result_o` unchanged.
- Build without `MIRISCV_DIV_EN`: DIV 6/3 completes next cycle with result 0 and `illegal_o` 1. Unknown code 01111 behaves the same.
- Async reset asserted mid-MUL: outputs take their reset values immediately, and no spurious `valid_o` appears after release.
